sar_sample_averager: RTL and testbench
======================================

Name: sar_sample_averager

Overview:
Downstream consumer of the SAR ADC digital core. It captures each finished conversion result on the rising edge of the core's done flag. It accumulates 2^LOG2_AVG consecutive samples and presents their truncated mean on a valid/ready output port. Results that cannot be delivered are flagged on a sticky overrun output.

Parameters:
SIZE, 4, conversion result width in bits; must match the SAR core's SIZE.
LOG2_AVG, 2, log2 of the number of samples averaged per result; legal range 0..8, where 0 means pass-through.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  when low, done edges are ignored and no capture occurs.
clear  input  1  synchronous clear of the accumulator, sample counter, output buffer and overrun.
sar_done  input  1  done flag from the SAR core; high while a result is available.
sar_data  input  SIZE  digital_out from the SAR core; valid whenever sar_done is high.
avg_valid  output  1  output buffer holds an undelivered average.
avg_ready  input  1  downstream accepts avg_data this cycle.
avg_data  output  SIZE  averaged result.
overrun  output  1  sticky: a completed average was dropped.
sample_count  output  LOG2_AVG+1  samples accumulated toward the current average.

Behaviour:
- Reset (reset=0, asynchronous): accumulator=0, sample_count=0, done_q=0, avg_valid=0, avg_data=0, overrun=0.
- Edge detect: done_q <= sar_done every cycle, regardless of enable.
  - capture = sar_done & ~done_q & enable.
  - A done level held high for many cycles yields exactly one capture.
  - An edge that occurs while enable=0 is never captured later.
- Capture: sar_data is sampled on the same clk edge on which capture is true.
  - Accumulator width is SIZE+LOG2_AVG; it cannot overflow.
- Capture with sample_count < 2^LOG2_AVG-1:
  - accumulator += sar_data.
  - sample_count += 1.
- Capture with sample_count == 2^LOG2_AVG-1 (completing capture):
  - result = (accumulator + sar_data) >> LOG2_AVG, truncating toward zero.
  - accumulator <= 0 and sample_count <= 0 on the same edge.
- Output buffer, two states:
  - EMPTY (avg_valid=0) goes to FULL on a completing capture; avg_data <= result; avg_valid is high the cycle after the capture edge (1-cycle latency).
  - FULL, avg_ready=1, no completing capture: transfer occurs; go to EMPTY, avg_valid=0 next cycle, avg_data keeps its last value.
  - FULL, avg_ready=1, completing capture in the same cycle: transfer occurs, avg_data <= new result, stay FULL with no bubble.
  - FULL, avg_ready=0, completing capture: the new result is discarded, avg_data is unchanged, overrun <= 1.
  - avg_data and avg_valid never change while avg_valid=1 and avg_ready=0, except by clear or reset.
- overrun is cleared only by clear or reset.
- clear=1 has priority over capture and transfer in the same cycle.
  - accumulator, sample_count, avg_valid and overrun go to 0; avg_data goes to 0.
  - done_q still updates, so a done edge coincident with clear is lost.
- LOG2_AVG=0: every capture is a completing capture, result = sar_data, and sample_count is always 0.
- avg_ready is ignored while avg_valid=0.

Test Plan:
- SIZE=4, LOG2_AVG=2; four conversions with sar_data 15,15,15,15, each done held high 3 cycles, avg_ready=1 -> exactly one avg_valid pulse with avg_data=15, one cycle after the 4th done edge; sample_count walks 1,2,3,0.
- Samples 0,5,10,1 (sum 16) -> avg_data=4; then samples 1,1,1,2 (sum 5) -> avg_data=1 (truncation); overrun stays 0.
- avg_ready=0; eight samples all =3 then eight all =9 -> avg_data=3 held with avg_valid=1; overrun=1 after the 8th sample; raise avg_ready -> one transfer of 3, then avg_valid=0.
- avg_ready=1 throughout; the completing capture lands in the same cycle as a transfer -> avg_valid stays high with no bubble and avg_data updates to the new average.
- Two samples captured, then reset pulsed low mid-cycle -> all outputs 0 immediately (asynchronous); the next four samples 8,8,8,8 give avg_data=8, with no contribution from the pre-reset samples.
- enable=0 during one done edge and clear=1 coincident with another -> neither is counted (sample_count unchanged or 0); a clear while overrun=1 and avg_valid=1 drops both to 0 next cycle.

Source files
------------

// File: rtl/sar_sample_averager_if.sv
// Output handshake of the sample averager.
//   avg_valid : averager holds an undelivered result
//   avg_ready : consumer accepts avg_data this cycle
//   avg_data  : averaged result (SIZE bits)
// master = averager side, slave = consumer side.
interface sar_sample_averager_if #(
   parameter int unsigned SIZE = 4
);
   logic            avg_valid;
   logic            avg_ready;
   logic [SIZE-1:0] avg_data;

   modport master (output avg_valid, output avg_data, input avg_ready);
   modport slave  (input avg_valid, input avg_data, output avg_ready);
endinterface

// File: rtl/sar_sample_averager.sv
// Averages 2^LOG2_AVG consecutive SAR conversion results and offers the
// truncated mean on a valid/ready port.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   enable       : when low, done edges are ignored
//   clear        : synchronous clear of accumulator, count, buffer, overrun
//   sar_done     : SAR core done flag; a rising edge marks a new result
//   sar_data     : SAR core result, valid while sar_done is high
//   avg_if       : avg_valid / avg_ready / avg_data output handshake
//   overrun      : sticky, a completed average was dropped
//   sample_count : samples accumulated toward the current average
module sar_sample_averager #(
   parameter int unsigned SIZE     = 4,
   parameter int unsigned LOG2_AVG = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                sar_done,
   input  logic [SIZE-1:0]     sar_data,
   sar_sample_averager_if.master avg_if,
   output logic                overrun,
   output logic [LOG2_AVG:0]   sample_count
);

   localparam int unsigned ACC_W = SIZE + LOG2_AVG;
   localparam int unsigned CNT_W = LOG2_AVG + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_AVG) - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   buf_state_t       state, next_state;
   logic             done_q;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic [SIZE-1:0]  result;
   logic [SIZE-1:0]  avg_data_q;
   logic             capture;
   logic             completing;
   logic             load;
   logic             set_overrun;

   assign capture    = sar_done & ~done_q & enable;
   assign completing = capture & (sample_count == LAST);
   // Accumulator is wide enough for 2^LOG2_AVG full-scale samples.
   assign sum        = acc + ACC_W'(sar_data);
   assign result     = SIZE'(sum >> LOG2_AVG);

   assign avg_if.avg_valid = (state == FULL);
   assign avg_if.avg_data  = avg_data_q;

   // Edge detector runs regardless of enable/clear so a held or masked
   // done level never produces a late capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= sar_done;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc          <= '0;
         sample_count <= '0;
      end else if (clear) begin
         acc          <= '0;
         sample_count <= '0;
      end else if (completing) begin
         acc          <= '0;
         sample_count <= '0;
      end else if (capture) begin
         acc          <= sum;
         sample_count <= sample_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // A completing capture loads the buffer when it is empty or is being
   // drained this cycle; otherwise the new result is dropped.
   always_comb begin
      next_state  = state;
      load        = 1'b0;
      set_overrun = 1'b0;
      if (clear) begin
         next_state = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (completing) begin
                  next_state = FULL;
                  load       = 1'b1;
               end
            end
            FULL: begin
               if (avg_if.avg_ready) begin
                  if (completing) begin
                     load = 1'b1;
                  end else begin
                     next_state = EMPTY;
                  end
               end else if (completing) begin
                  set_overrun = 1'b1;
               end
            end
            default: next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         avg_data_q <= '0;
         overrun    <= 1'b0;
      end else if (clear) begin
         avg_data_q <= '0;
         overrun    <= 1'b0;
      end else begin
         if (load) begin
            avg_data_q <= result;
         end
         if (set_overrun) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sar_sample_averager.sv
// Self-checking bench for sar_sample_averager (SIZE=4, LOG2_AVG=2).
// A small model accumulates each driven sample and queues the expected
// average; a monitor pops and compares on every valid/ready transfer.
module tb_sar_sample_averager;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       clear;
   logic       sar_done;
   logic [3:0] sar_data;
   logic       overrun;
   logic [2:0] sample_count;

   sar_sample_averager_if #(.SIZE(4)) avg_if ();

   sar_sample_averager #(
      .SIZE     (4),
      .LOG2_AVG (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .sar_done     (sar_done),
      .sar_data     (sar_data),
      .avg_if       (avg_if),
      .overrun      (overrun),
      .sample_count (sample_count)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned n_xfer   = 0;

   logic [3:0]  sb[$];
   int unsigned m_sum;
   int unsigned m_cnt;
   bit          drop;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One conversion: raise done with data, hold it, then drop it.
   task automatic conv(input logic [3:0] d, input int unsigned hold, input bit counted);
      bit completed;
      completed = 1'b0;
      sar_data  = d;
      sar_done  = 1'b1;
      tick();
      if (counted) begin
         m_sum += d;
         m_cnt++;
         if (m_cnt == 4) begin
            if (!drop) sb.push_back(4'(m_sum >> 2));
            m_sum     = 0;
            m_cnt     = 0;
            completed = 1'b1;
         end
      end
      chk("sample_count", 32'(sample_count), m_cnt);
      if (completed) chk("valid_after_complete", 32'(avg_if.avg_valid), 1);
      repeat (hold - 1) tick();
      sar_done = 1'b0;
      tick();
   endtask

   // Transfer happens on the posedge following a negedge with valid & ready.
   always @(negedge clk) begin
      if (reset && !clear && avg_if.avg_valid && avg_if.avg_ready) begin
         n_xfer++;
         chk("xfer_pending", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) chk("xfer_data", 32'(avg_if.avg_data), 32'(sb.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned base;
      logic [3:0] t2 [8];
      t2 = '{4'd0, 4'd5, 4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
      reset            = 1'b0;
      enable           = 1'b1;
      clear            = 1'b0;
      sar_done         = 1'b0;
      sar_data         = '0;
      avg_if.avg_ready = 1'b0;
      m_sum = 0;
      m_cnt = 0;
      drop  = 1'b0;
      repeat (2) tick();
      chk("rst_valid", 32'(avg_if.avg_valid), 0);
      chk("rst_data", 32'(avg_if.avg_data), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_count", 32'(sample_count), 0);
      reset = 1'b1;
      tick();

      // Four full-scale samples, long done pulses, consumer always ready.
      avg_if.avg_ready = 1'b1;
      base = n_xfer;
      for (int i = 0; i < 4; i++) conv(4'd15, 3, 1'b1);
      chk("t1_xfers", n_xfer - base, 1);
      chk("t1_valid_low", 32'(avg_if.avg_valid), 0);

      // Exact mean, then a truncated mean.
      for (int i = 0; i < 8; i++) conv(t2[i], 2, 1'b1);
      chk("t2_overrun", 32'(overrun), 0);
      chk("t2_last_data", 32'(avg_if.avg_data), 1);

      // Stalled consumer: first average held, later ones dropped.
      avg_if.avg_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) drop = 1'b1;
         conv(4'd3, 2, 1'b1);
         if (i == 6) chk("t3_overrun_pre", 32'(overrun), 0);
      end
      chk("t3_overrun", 32'(overrun), 1);
      for (int i = 0; i < 8; i++) conv(4'd9, 2, 1'b1);
      chk("t3_hold_valid", 32'(avg_if.avg_valid), 1);
      chk("t3_hold_data", 32'(avg_if.avg_data), 3);
      drop = 1'b0;
      base = n_xfer;
      avg_if.avg_ready = 1'b1;
      repeat (2) tick();
      chk("t3_xfers", n_xfer - base, 1);
      chk("t3_valid_low", 32'(avg_if.avg_valid), 0);
      chk("t3_overrun_sticky", 32'(overrun), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t3_overrun_cleared", 32'(overrun), 0);

      // Completing capture coincides with a transfer: no bubble.
      avg_if.avg_ready = 1'b0;
      for (int i = 0; i < 4; i++) conv(4'd6, 2, 1'b1);
      for (int i = 0; i < 3; i++) conv(4'd12, 2, 1'b1);
      chk("t4_full_before", 32'(avg_if.avg_valid), 1);
      avg_if.avg_ready = 1'b1;
      sar_data = 4'd12;
      sar_done = 1'b1;
      tick();
      m_sum = 0;
      m_cnt = 0;
      sb.push_back(4'd12);
      chk("t4_no_bubble", 32'(avg_if.avg_valid), 1);
      chk("t4_new_data", 32'(avg_if.avg_data), 12);
      chk("t4_overrun", 32'(overrun), 0);
      sar_done = 1'b0;
      tick();
      chk("t4_drained", 32'(avg_if.avg_valid), 0);

      // Asynchronous reset mid-cycle discards partial accumulation.
      conv(4'd7, 2, 1'b1);
      conv(4'd7, 2, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t5_count", 32'(sample_count), 0);
      chk("t5_valid", 32'(avg_if.avg_valid), 0);
      chk("t5_data", 32'(avg_if.avg_data), 0);
      chk("t5_overrun", 32'(overrun), 0);
      #1 reset = 1'b1;
      m_sum = 0;
      m_cnt = 0;
      tick();
      for (int i = 0; i < 4; i++) conv(4'd8, 2, 1'b1);
      chk("t5_data_after", 32'(avg_if.avg_data), 8);

      // Masked edge and an edge coincident with clear are not counted.
      conv(4'd2, 2, 1'b1);
      enable = 1'b0;
      conv(4'd9, 2, 1'b0);
      enable = 1'b1;
      chk("t6_masked", 32'(sample_count), 1);
      sar_data = 4'd9;
      sar_done = 1'b1;
      clear    = 1'b1;
      tick();
      clear = 1'b0;
      m_sum = 0;
      m_cnt = 0;
      chk("t6_clear_count", 32'(sample_count), 0);
      tick();
      chk("t6_held_done", 32'(sample_count), 0);
      sar_done = 1'b0;
      tick();
      conv(4'd4, 2, 1'b1);
      m_sum = 0;
      m_cnt = 0;
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // Clear drops a held result and the overrun flag together.
      avg_if.avg_ready = 1'b0;
      drop = 1'b1;
      for (int i = 0; i < 8; i++) conv(4'd5, 2, 1'b1);
      chk("t6_full", 32'(avg_if.avg_valid), 1);
      chk("t6_ovr_set", 32'(overrun), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      drop  = 1'b0;
      chk("t6_clr_valid", 32'(avg_if.avg_valid), 0);
      chk("t6_clr_overrun", 32'(overrun), 0);
      chk("t6_clr_data", 32'(avg_if.avg_data), 0);
      chk("t6_clr_count", 32'(sample_count), 0);

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
